// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin req/ack arbiter sharing one ALU between two requesters; `ALU_ARB_FIXED_PRIORITY_EN selects fixed priority (port 0 wins ties).
module alu_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] operation0,
  input  logic [7:0] operation1,
  input  logic [7:0] op1_0,
  input  logic [7:0] op2_0,
  input  logic [7:0] op1_1,
  input  logic [7:0] op2_1,
  input  logic       cpu_carry0,
  input  logic       cpu_carry1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] result_l,
  output logic [7:0] result_h,
  output logic       carry,
  output logic       zero,
  output logic       sign,
  output logic       grant_id,
  output logic       busy,
  output logic       alu_enable,
  output logic [7:0] alu_operation,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic       alu_cpu_carry,
  input  logic [7:0] alu_result_l,
  input  logic [7:0] alu_result_h,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic last_grant, win, start;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
  assign win = !req0;
`else
  assign win = (req0 && req1) ? !last_grant : req1;
`endif
  assign start = state == IDLE && (req0 || req1);
  assign ack0 = state == DONE && !grant_id;
  assign ack1 = state == DONE && grant_id;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? BUSY : IDLE;
      BUSY:    state_nx = cnt == 4'd0 ? DONE : BUSY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      alu_enable <= 1'b0;
    end else begin
      state      <= state_nx;
      busy       <= state_nx != IDLE;
      alu_enable <= state_nx == BUSY;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt           <= 4'd0;
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      alu_operation <= 8'h00;
      alu_op1       <= 8'h00;
      alu_op2       <= 8'h00;
      alu_cpu_carry <= 1'b0;
      result_l      <= 8'h00;
      result_h      <= 8'h00;
      carry         <= 1'b0;
      zero          <= 1'b0;
      sign          <= 1'b0;
    end else if (start) begin
      cnt           <= 4'(LATENCY - 1);
      grant_id      <= win;
      last_grant    <= win;
      alu_operation <= win ? operation1 : operation0;
      alu_op1       <= win ? op1_1 : op1_0;
      alu_op2       <= win ? op2_1 : op2_0;
      alu_cpu_carry <= win ? cpu_carry1 : cpu_carry0;
    end else if (state == BUSY) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else begin
        result_l <= alu_result_l;
        result_h <= alu_result_h;
        carry    <= alu_carry;
        zero     <= alu_zero;
        sign     <= alu_sign;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench driving a LATENCY=1 and a LATENCY=4 arbiter from shared stimulus with an adder ALU stub.
module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [7:0] operation0 = 8'h00, operation1 = 8'h00;
  logic [7:0] op1_0 = 8'h00, op2_0 = 8'h00, op1_1 = 8'h00, op2_1 = 8'h00;
  logic cpu_carry0 = 1'b0, cpu_carry1 = 1'b0;
  logic ack0_w[2], ack1_w[2], carry_w[2], zero_w[2], sign_w[2], gid_w[2], busy_w[2], en_w[2], acin_w[2];
  logic [7:0] rl_w[2], rh_w[2], aop_w[2], a1_w[2], a2_w[2];
  logic [7:0] arl_w[2], arh_w[2];
  logic ac_w[2], az_w[2], as_w[2];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [8:0] sum;
    assign sum    = {1'b0, a1_w[g]} + {1'b0, a2_w[g]};
    assign arl_w[g] = sum[7:0];
    assign arh_w[g] = {7'b0, sum[8]};
    assign ac_w[g]  = sum[8];
    assign az_w[g]  = sum[7:0] == 8'h00;
    assign as_w[g]  = sum[7];
    alu_arbiter #(.LATENCY(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .operation0(operation0), .operation1(operation1),
      .op1_0(op1_0), .op2_0(op2_0), .op1_1(op1_1), .op2_1(op2_1),
      .cpu_carry0(cpu_carry0), .cpu_carry1(cpu_carry1),
      .ack0(ack0_w[g]), .ack1(ack1_w[g]), .result_l(rl_w[g]), .result_h(rh_w[g]),
      .carry(carry_w[g]), .zero(zero_w[g]), .sign(sign_w[g]), .grant_id(gid_w[g]),
      .busy(busy_w[g]), .alu_enable(en_w[g]), .alu_operation(aop_w[g]),
      .alu_op1(a1_w[g]), .alu_op2(a2_w[g]), .alu_cpu_carry(acin_w[g]),
      .alu_result_l(arl_w[g]), .alu_result_h(arh_w[g]),
      .alu_carry(ac_w[g]), .alu_zero(az_w[g]), .alu_sign(as_w[g])
    );
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask
  initial begin
    logic w;
    do_reset();
    for (int g = 0; g < 2; g++) begin
      check("rst_busy", busy_w[g], 0);
      check("rst_en", en_w[g], 0);
      check("rst_ack", {ack0_w[g], ack1_w[g]}, 0);
      check("rst_gid", gid_w[g], 0);
      check("rst_res", {rh_w[g], rl_w[g]}, 16'h0000);
      check("rst_flags", {carry_w[g], zero_w[g], sign_w[g]}, 0);
      check("rst_alu_in", {aop_w[g], a1_w[g]}, 16'h0000);
      check("rst_alu_in2", {a2_w[g], 7'b0, acin_w[g]}, 16'h0000);
    end
    // single request, LATENCY=1
    req0 = 1'b1; operation0 = 8'h01; op1_0 = 8'h12; op2_0 = 8'h34; cpu_carry0 = 1'b1;
    tick();
    req0 = 1'b0;
    check("s_en", en_w[0], 1);
    check("s_busy", busy_w[0], 1);
    check("s_alu_in", {aop_w[0], a1_w[0]}, 16'h0112);
    check("s_alu_in2", {a2_w[0], 7'b0, acin_w[0]}, 16'h3401);
    check("s_ack_early", {ack0_w[0], ack1_w[0]}, 0);
    tick();
    check("s_ack0", ack0_w[0], 1);
    check("s_ack1", ack1_w[0], 0);
    check("s_res", {rh_w[0], rl_w[0]}, 16'h0046);
    check("s_zero", zero_w[0], 0);
    check("s_gid", gid_w[0], 0);
    check("s_en_done", en_w[0], 0);
    tick();
    check("s_ack_idle", {ack0_w[0], ack1_w[0]}, 0);
    check("s_res_hold", rl_w[0], 8'h46);
    check("s_busy_idle", busy_w[0], 0);
    check("s_alu_hold", a1_w[0], 8'h12);
    // tie, LATENCY=1
    do_reset();
    op1_0 = 8'h01; op2_0 = 8'h02; op1_1 = 8'h10; op2_1 = 8'h20;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      w = 1'b0;
`else
      w = k[0];
`endif
      tick();
      check("t_gid", gid_w[0], 16'(w));
      check("t_busy", busy_w[0], 1);
      tick();
      check("t_acks", {ack1_w[0], ack0_w[0]}, w ? 16'h2 : 16'h1);
      check("t_res", rl_w[0], w ? 8'h30 : 8'h03);
      tick();
      check("t_idle", busy_w[0], 0);
    end
    // operand isolation, LATENCY=4
    do_reset();
    req0 = 1'b1; op1_0 = 8'h12; op2_0 = 8'h34;
    tick();
    req0 = 1'b0; op1_0 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      check("i_op1", a1_w[1], 8'h12);
      check("i_en", en_w[1], 1);
      check("i_ack", ack0_w[1], 0);
      tick();
    end
    check("i_ack0", ack0_w[1], 1);
    check("i_res", rl_w[1], 8'h46);
    // reset mid-operation, LATENCY=4
    do_reset();
    req0 = 1'b1; op1_0 = 8'h12;
    tick();
    req0 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("r_busy", busy_w[1], 0);
    check("r_en", en_w[1], 0);
    check("r_res", rl_w[1], 8'h00);
    check("r_op1", a1_w[1], 8'h00);
    for (int i = 0; i < 5; i++) begin
      check("r_noack", {ack0_w[1], ack1_w[1]}, 0);
      tick();
    end
    req1 = 1'b1; op1_1 = 8'h05; op2_1 = 8'h06;
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("r_ack1", {ack1_w[1], ack0_w[1]}, 16'h2);
    check("r_gid", gid_w[1], 1);
    check("r_res2", rl_w[1], 8'h0B);
    // withdrawn req1, held req0, LATENCY=4
    do_reset();
    req0 = 1'b1; op1_0 = 8'h01; op2_0 = 8'h02;
    tick();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("h_ack0", {ack1_w[1], ack0_w[1]}, 16'h1);
    check("h_gid", gid_w[1], 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("h_gap", {ack1_w[1], ack0_w[1]}, 0);
      if (i == 0) check("h_idle", busy_w[1], 0);
      else check("h_gid2", gid_w[1], 0);
    end
    tick();
    check("h_ack0_again", {ack1_w[1], ack0_w[1]}, 16'h1);
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("h_no_ack1", {ack1_w[1], ack0_w[1]}, 0);
      check("h_settle", busy_w[1], 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 8-bit `alu` between two requesters, CPU execute (port 0) and the auxiliary address/interrupt unit (port 1), via per-requester req/ack handshakes. It arbitrates, latches the winner's operation and operands, drives the ALU for a fixed number of cycles, captures results and flags, and returns them with a one-cycle ack. It sits between the requesters and the `alu` instance and is the only driver of the ALU inputs.

## Interface
- `LATENCY`, 1, cycles `alu_enable` is held before results are sampled; legal range 1..15.

- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `req0` / `req1`  input  1  request from requester 0 / 1.
- `operation0` / `operation1`  input  8  ALU operation code.
- `op1_0`, `op2_0` / `op1_1`, `op2_1`  input  8  operands.
- `cpu_carry0` / `cpu_carry1`  input  1  carry-in.
- `ack0` / `ack1`  output  1  one-cycle completion strobe.
- `result_l`, `result_h`  output  8  captured ALU result, shared by both requesters.
- `carry`, `zero`, `sign`  output  1  captured flags.
- `grant_id`  output  1  requester owning the current or last transaction.
- `busy`  output  1  high in every state except IDLE.
- `alu_enable`  output  1  to ALU `enable`.
- `alu_operation`, `alu_op1`, `alu_op2`  output  8  to ALU.
- `alu_cpu_carry`  output  1  to ALU.
- `alu_result_l`, `alu_result_h`  input  8  from ALU.
- `alu_carry`, `alu_zero`, `alu_sign`  input  1  from ALU.

## Operation
- States: IDLE, BUSY, DONE. 4-bit down-counter `cnt`.
- IDLE: if any req is sampled high, choose a winner, latch its operation, operands and carry into internal registers, set `grant_id`, load `cnt = LATENCY-1`, and go to BUSY. With no req, stay in IDLE.
- Arbitration is round-robin. A single requester always wins. If both request, the winner is the one not equal to `last_grant`. `last_grant` updates on every grant.
- BUSY: `alu_enable=1`. `alu_*` outputs come from the latched registers, not the live inputs.
  - If `cnt != 0`: decrement.
  - If `cnt == 0`: capture `alu_result_*` and flags into the output registers, then go to DONE.
- DONE: `ack[grant_id]=1` for exactly one cycle, `alu_enable=0`, then go to IDLE.
- Operand changes after the grant have no effect on the transaction in flight.
- A req dropped before it is granted is silently withdrawn.
- A req still high in the IDLE cycle after DONE is a new transaction. Requesters must drop req in the cycle they see ack.
- Result and flag outputs hold until the next capture. They are not cleared by ack.
- `alu_*` outputs keep their last latched values while idle, with `alu_enable=0`.

## Timing
- Reset values (rst low at a clock edge): state=IDLE; `cnt=0`; `last_grant=1` so port 0 wins the first tie; `grant_id=0`; `ack0=ack1=0`; `busy=0`; `alu_enable=0`; `alu_operation`, `alu_op1`, `alu_op2`, `alu_cpu_carry`, `result_l`, `result_h`, `carry`, `zero` and `sign` all 0.
- Reset mid-operation aborts the transaction with no ack, and any in-flight ALU output is discarded.
- Taking the edge where req is sampled in IDLE as edge 0:
  - `alu_enable` rises after edge 0.
  - Capture happens at edge LATENCY.
  - Ack is high in the cycle after edge LATENCY.
  - So req-to-ack latency is LATENCY+1 cycles.
- Back-to-back throughput is one transaction per LATENCY+2 cycles (IDLE, BUSY×LATENCY, DONE).
- A requester that loses a tie is granted in the IDLE cycle that follows the winner's DONE.
- `busy` is registered and equals (state != IDLE).

## Configuration
- `ALU_ARB_FIXED_PRIORITY_EN`
  - Defined: fixed priority. req0 always wins a tie and `last_grant` is ignored, so port 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Single request: LATENCY=1; req0 with operation=8'h01, op1=8'h12, op2=8'h34, carry=1; ALU stub drives result_l=8'h46, result_h=8'h00, zero=0 → `alu_*` carry 01/12/34/1, ack0 is high exactly 2 cycles after req is sampled, result_l=8'h46, grant_id=0, ack1 never asserted.
- Tie, round-robin: req0 and req1 held high together from reset → grant order 0,1,0,1; acks alternate every 3 cycles (LATENCY=1). With `ALU_ARB_FIXED_PRIORITY_EN` defined → only ack0 fires.
- Operand isolation: after the grant, change op1_0 from 8'h12 to 8'hFF during BUSY (LATENCY=4) → `alu_op1` stays 8'h12 for all 4 BUSY cycles; ack0 arrives at cycle 5.
- Reset mid-operation: rst low during the second BUSY cycle (LATENCY=4) → next cycle is IDLE, `alu_enable=0`, result_l=8'h00, no ack; a fresh req1 completes normally afterwards.
- Withdrawn and held requests: req1 is high one cycle while the arbiter is BUSY, then dropped → never serviced. req0 held high through ack → a second transaction starts, giving ack0 again LATENCY+2 cycles later.
